pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage MIPS core.
- Merges stall requests from the IF, ID, EX and MEM stages into the shared `stall[5:0]` vector. That vector is consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- On an exception or ERET it generates the flush and redirect-PC signals, then masks stale stall requests during refill.
- Keeps a saturating stall-cycle counter and a sticky stall watchdog for debug.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_ctrl_sat_counter.sv | 22 ++
 rtl/pipe_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stall vectors, the ERET code and FSM states.
package pipe_ctrl_pkg;

  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_IF   = 6'b000011;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;
  localparam logic [5:0]  STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_ERET   = 32'h0000_000e;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_REFILL = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, drives flush/redirect on exceptions,
// masks IF/ID stalls during refill, and keeps a stall-cycle counter and sticky watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int unsigned REFILL_CYCLES = 2,
  parameter int unsigned WDOG_LIMIT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles_o,
  output logic        stall_timeout_o
);

  localparam int unsigned WD_W        = $clog2(WDOG_LIMIT + 1);
  localparam logic [3:0]  REFILL_INIT = 4'(REFILL_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_LIMIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  refill_q, refill_d;
  logic        stalled;
  logic [WD_W-1:0] wd_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      refill_q <= '0;
    end else begin
      state_q  <= state_d;
      refill_q <= refill_d;
    end
  end

  always_comb begin
    stall    = STALL_NONE;
    flush    = 1'b0;
    new_pc   = ZERO_WORD;
    state_d  = state_q;
    refill_d = refill_q;
    if (!rst) begin
      if (excepttype_i != '0) begin
        flush    = 1'b1;
        new_pc   = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
        state_d  = ST_REFILL;
        refill_d = REFILL_INIT;
      end else begin
        // IF/ID requests during refill are stale leftovers from the squashed stream
        if (stallreq_from_mem) begin
          stall = STALL_MEM;
        end else if (stallreq_from_ex) begin
          stall = STALL_EX;
        end else if (stallreq_from_id && (state_q == ST_RUN)) begin
          stall = STALL_ID;
        end else if (stallreq_from_if && (state_q == ST_RUN)) begin
          stall = STALL_IF;
        end
        if (state_q == ST_REFILL) begin
          if (refill_q <= 4'd1) begin
            state_d  = ST_RUN;
            refill_d = '0;
          end else begin
            refill_d = refill_q - 4'd1;
          end
        end
      end
    end
  end

  assign stalled = (stall != STALL_NONE);

  sat_counter #(.W(32)) u_stall_cycles (
    .clk   (clk),
    .rst   (rst),
    .inc   (stalled),
    .clr   (1'b0),
    .count (stall_cycles_o)
  );

  sat_counter #(.W(WD_W)) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .inc   (stalled),
    .clr   (!stalled || flush),
    .count (wd_count)
  );

  // Flag on the edge that brings the consecutive count up to the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_timeout_o <= 1'b0;
    end else if (stalled && (wd_count >= WD_LAST)) begin
      stall_timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table with scoreboard plus a saturation sequence.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sif, sid, sex, smem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] cyc;
  logic        tmo;

  pipe_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .REFILL_CYCLES(2),
    .WDOG_LIMIT   (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (sif),
    .stallreq_from_id (sid),
    .stallreq_from_ex (sex),
    .stallreq_from_mem(smem),
    .excepttype_i     (exc),
    .cp0_epc_i        (epc),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_cycles_o   (cyc),
    .stall_timeout_o  (tmo)
  );

  // Small-width saturating counter to exercise the hold-at-max path quickly
  logic       sc_rst, sc_inc, sc_clr;
  logic [1:0] sc_cnt;

  sat_counter #(.W(2)) u_sat (
    .clk  (clk),
    .rst  (sc_rst),
    .inc  (sc_inc),
    .clr  (sc_clr),
    .count(sc_cnt)
  );

  typedef struct packed {
    logic        rst;
    logic        r_if;
    logic        r_id;
    logic        r_ex;
    logic        r_mem;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
  } exp_t;

  localparam int NV = 28;
  localparam logic [31:0] JUNK = 32'hdead_beec;
  localparam logic [31:0] EPC  = 32'h0040_1234;

  vec_t  vecs [NV];
  exp_t  sb[$];
  int    tests = 0;
  int    fails = 0;

  int unsigned m_cyc, m_wd;
  logic        m_to;
  logic        m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic fi, input logic fd, input logic fe,
                              input logic fm, input logic [31:0] x, input logic [31:0] p,
                              input logic [5:0] es, input logic ef, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.r_if = fi; v.r_id = fd; v.r_ex = fe; v.r_mem = fm;
    v.exc = x; v.epc = p; v.e_stall = es; v.e_flush = ef; v.e_pc = ep;
    return v;
  endfunction

  initial begin
    exp_t e;
    logic [1:0] sc_exp;

    //                rst if id ex mem  exc           epc   stall      flush pc
    vecs[0]  = mk(1, 1, 1, 1, 1, 32'h0,        JUNK, 6'b000000, 0, 32'h0);
    vecs[1]  = mk(1, 1, 1, 1, 1, 32'h0,        JUNK, 6'b000000, 0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 32'h0,        JUNK, 6'b001111, 0, 32'h0);
    vecs[3]  = mk(0, 1, 1, 1, 1, 32'h0,        JUNK, 6'b011111, 0, 32'h0);
    vecs[4]  = mk(0, 1, 1, 1, 0, 32'h0,        JUNK, 6'b001111, 0, 32'h0);
    vecs[5]  = mk(0, 1, 1, 0, 0, 32'h0,        JUNK, 6'b000111, 0, 32'h0);
    vecs[6]  = mk(0, 1, 0, 0, 0, 32'h0,        JUNK, 6'b000011, 0, 32'h0);
    vecs[7]  = mk(0, 0, 0, 0, 1, 32'h8,        EPC,  6'b000000, 1, 32'h20);
    vecs[8]  = mk(0, 0, 1, 0, 0, 32'h0,        JUNK, 6'b000000, 0, 32'h0);
    vecs[9]  = mk(0, 0, 0, 1, 0, 32'h0,        JUNK, 6'b001111, 0, 32'h0);
    vecs[10] = mk(0, 0, 1, 0, 0, 32'h0,        JUNK, 6'b000111, 0, 32'h0);
    vecs[11] = mk(0, 0, 0, 0, 0, 32'h0000_000e, EPC, 6'b000000, 1, EPC);
    vecs[12] = mk(0, 1, 0, 0, 0, 32'h0,        JUNK, 6'b000000, 0, 32'h0);
    vecs[13] = mk(0, 0, 0, 0, 0, 32'h8,        EPC,  6'b000000, 1, 32'h20);
    vecs[14] = mk(0, 0, 1, 0, 0, 32'h0,        JUNK, 6'b000000, 0, 32'h0);
    vecs[15] = mk(0, 0, 1, 0, 0, 32'h0,        JUNK, 6'b000000, 0, 32'h0);
    vecs[16] = mk(0, 0, 1, 0, 0, 32'h0,        JUNK, 6'b000111, 0, 32'h0);
    vecs[17] = mk(0, 0, 0, 0, 0, 32'h0,        JUNK, 6'b000000, 0, 32'h0);
    vecs[18] = mk(1, 0, 0, 0, 0, 32'h0,        JUNK, 6'b000000, 0, 32'h0);
    vecs[19] = mk(0, 0, 0, 1, 0, 32'h0,        JUNK, 6'b001111, 0, 32'h0);
    vecs[20] = mk(0, 0, 0, 1, 0, 32'h0,        JUNK, 6'b001111, 0, 32'h0);
    vecs[21] = mk(0, 0, 0, 1, 0, 32'h0,        JUNK, 6'b001111, 0, 32'h0);
    vecs[22] = mk(0, 0, 0, 1, 0, 32'h0,        JUNK, 6'b001111, 0, 32'h0);
    vecs[23] = mk(0, 0, 0, 0, 0, 32'h0,        JUNK, 6'b000000, 0, 32'h0);
    vecs[24] = mk(0, 0, 0, 0, 0, 32'h0,        JUNK, 6'b000000, 0, 32'h0);
    vecs[25] = mk(0, 0, 0, 0, 0, 32'h8,        EPC,  6'b000000, 1, 32'h20);
    vecs[26] = mk(1, 0, 1, 0, 1, 32'h8,        EPC,  6'b000000, 0, 32'h0);
    vecs[27] = mk(0, 0, 1, 0, 0, 32'h0,        JUNK, 6'b000111, 0, 32'h0);

    rst = 1'b1; sif = 1'b0; sid = 1'b0; sex = 1'b0; smem = 1'b0;
    exc = '0; epc = '0;
    sc_rst = 1'b1; sc_inc = 1'b0; sc_clr = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; sif = vecs[i].r_if; sid = vecs[i].r_id;
      sex = vecs[i].r_ex; smem = vecs[i].r_mem;
      exc = vecs[i].exc; epc = vecs[i].epc;
      sb.push_back('{stall: vecs[i].e_stall, flush: vecs[i].e_flush, pc: vecs[i].e_pc});

      @(negedge clk);
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL v%0d scoreboard: got empty queue expected one entry", i);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d stall", i), 32'(stall), 32'(e.stall));
        check($sformatf("v%0d flush", i), 32'(flush), 32'(e.flush));
        check($sformatf("v%0d new_pc", i), new_pc, e.pc);
      end
      if (m_valid) begin
        check($sformatf("v%0d stall_cycles", i), cyc, m_cyc);
        check($sformatf("v%0d timeout", i), 32'(tmo), 32'(m_to));
      end
      if (i == 23) begin
        check("wdog count after 4 stalls", cyc, 32'd4);
        check("wdog flag after 4 stalls", 32'(tmo), 32'd1);
      end

      @(posedge clk);
      if (vecs[i].rst) begin
        m_cyc = 0; m_wd = 0; m_to = 1'b0; m_valid = 1'b1;
      end else begin
        if (vecs[i].e_stall != 6'b0 && m_cyc != 32'hFFFF_FFFF) m_cyc++;
        if (vecs[i].e_stall == 6'b0 || vecs[i].e_flush) m_wd = 0;
        else m_wd++;
        if (m_wd >= 4) m_to = 1'b1;
      end
      #1;
    end

    // Saturation: reset, then increment past the maximum and confirm it holds
    rst = 1'b1; sif = 1'b0; sid = 1'b0; sex = 1'b0; smem = 1'b0; exc = '0;
    sc_rst = 1'b1;
    @(posedge clk); #1;
    check("sat reset", 32'(sc_cnt), 32'd0);
    sc_rst = 1'b0; sc_inc = 1'b1;
    sc_exp = 2'd0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (sc_exp != 2'd3) sc_exp = sc_exp + 2'd1;
      check($sformatf("sat inc%0d", k), 32'(sc_cnt), 32'(sc_exp));
    end
    sc_clr = 1'b1;
    @(posedge clk); #1;
    check("sat clr over inc", 32'(sc_cnt), 32'd0);
    sc_clr = 1'b0;
    @(posedge clk); #1;
    check("sat inc after clr", 32'(sc_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
